// File: rtl/muldiv_seq.sv
// Sequential 64-bit multiply / unsigned divide / signed divide unit.
// One radix-2 step per cycle (64 steps), a sign-fix cycle, then a held result.
module muldiv_seq #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_UDIV = 2'b01;
  localparam logic [1:0] OP_SDIV = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  state_t              state, state_nxt;
  logic [6:0]          cnt;
  logic [1:0]          op_q;
  logic                neg;
  logic [DATA_W-1:0]   x;     // multiplier (MUL) or dividend/quotient (DIV)
  logic [DATA_W-1:0]   y;     // multiplicand (MUL) or divisor (DIV)
  logic [DATA_W-1:0]   acc;   // product (MUL) or partial remainder (DIV)
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     rem_sub;
  logic [DATA_W-1:0]   fix_res;
  logic                accept;
  logic                bypass;

  // Magnitude of a two's-complement value; the most negative value maps to 2^(W-1).
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] n;
    n = -v;
    return v[DATA_W-1] ? DATA_W'(n) : DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic           make_neg);
    logic signed [DATA_W-1:0] s;
    s = signed'(v);
    return make_neg ? DATA_W'(-s) : v;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign bypass    = (op == OP_RSVD) || ((op != OP_MUL) && (b == '0));

  always_comb begin
    rem_sh  = {acc, x[DATA_W-1]};
    rem_sub = rem_sh - {1'b0, y};
    fix_res = (op_q == OP_MUL) ? acc : apply_sign(x, neg);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = bypass ? DONE : CALC;
      CALC: if (cnt == 7'(DATA_W - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Control and architecturally visible outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      result      <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      if (bypass) begin
        result      <= '0;
        zero        <= 1'b1;
        div_by_zero <= (op != OP_RSVD);
      end
    end else if (state == CALC) begin
      cnt <= cnt + 7'd1;
    end else if (state == FIX) begin
      result      <= fix_res;
      zero        <= (fix_res == '0);
      div_by_zero <= 1'b0;
    end
  end

  // Iteration datapath; a set borrow bit in rem_sub means the divisor did not fit.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= op;
      acc  <= '0;
      if (op == OP_MUL) begin
        x   <= b;
        y   <= a;
        neg <= 1'b0;
      end else if (op == OP_SDIV) begin
        x   <= mag(signed'(a));
        y   <= mag(signed'(b));
        neg <= a[DATA_W-1] ^ b[DATA_W-1];
      end else begin
        x   <= a;
        y   <= b;
        neg <= 1'b0;
      end
    end else if (state == CALC) begin
      if (op_q == OP_MUL) begin
        if (x[0]) acc <= acc + y;
        y <= y << 1;
        x <= x >> 1;
      end else if (rem_sub[DATA_W]) begin
        acc <= rem_sh[DATA_W-1:0];
        x   <= {x[DATA_W-2:0], 1'b0};
      end else begin
        acc <= rem_sub[DATA_W-1:0];
        x   <= {x[DATA_W-2:0], 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: latency, results, flags,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        zero;
  logic        div_by_zero;

  int compared = 0;
  int mismatched = 0;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] av,
                        input logic [63:0] bv, input logic [63:0] exp_res,
                        input logic ez, input logic edbz, input int elat);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    op = o; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~av; b = ~bv; op = ~o;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    check({tag, ".latency"}, 64'(n), 64'(elat));
    check({tag, ".result"}, result, exp_res);
    check({tag, ".zero"}, 64'(zero), 64'(ez));
    check({tag, ".dbz"}, 64'(div_by_zero), 64'(edbz));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".ret_idle"}, 64'(in_ready), 64'd1);
    check({tag, ".ov_low"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
    logic seen;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result", result, 64'd0);
    check("rst.zero", 64'(zero), 64'd0);
    check("rst.dbz", 64'(div_by_zero), 64'd0);

    run_op("mul10x11", 2'b00, 64'd10, 64'd11, 64'h6E, 1'b0, 1'b0, 65);

    // Backpressure: hold the result for 10 cycles while new requests are offered.
    op = 2'b00; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    check("bp.latency", 64'(n), 64'd65);
    check("bp.result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    in_valid = 1'b1; op = 2'b01; a = 64'd99; b = 64'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp.hold_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
      check("bp.hold_valid", 64'(out_valid), 64'd1);
      check("bp.hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("bp.ret_idle", 64'(in_ready), 64'd1);
    check("bp.ov_low", 64'(out_valid), 64'd0);

    run_op("mul0x7", 2'b00, 64'd0, 64'd7, 64'd0, 1'b1, 1'b0, 65);
    run_op("udiv12_10", 2'b01, 64'd12, 64'd10, 64'd1, 1'b0, 1'b0, 65);
    run_op("sdivm12_10", 2'b10, 64'hFFFF_FFFF_FFFF_FFF4, 64'd10,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 65);
    run_op("sdivm12_m10", 2'b10, 64'hFFFF_FFFF_FFFF_FFF4, 64'hFFFF_FFFF_FFFF_FFF6,
           64'd1, 1'b0, 1'b0, 65);
    run_op("sdivmin_m1", 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1'b0, 1'b0, 65);
    run_op("udiv5_0", 2'b01, 64'd5, 64'd0, 64'd0, 1'b1, 1'b1, 0);
    run_op("udiv12_10b", 2'b01, 64'd12, 64'd10, 64'd1, 1'b0, 1'b0, 65);
    run_op("op11", 2'b11, 64'd9, 64'd3, 64'd0, 1'b1, 1'b0, 0);
    run_op("sdiv3_0", 2'b10, 64'd3, 64'd0, 64'd0, 1'b1, 1'b1, 0);
    run_op("udivmax_16", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16,
           64'h0FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 65);
    run_op("sdiv7_m2", 2'b10, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
           64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 65);

    // Reset asserted on the 30th CALC edge abandons the division.
    op = 2'b01; a = 64'd100; b = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.result", result, 64'd0);
    check("midrst.zero", 64'(zero), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst.no_output", 64'(seen), 64'd0);

    run_op("mul3x5", 2'b00, 64'd3, 64'd5, 64'd15, 1'b0, 1'b0, 65);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
